alu_share_arbiter: RTL

- Shares one combinational ALU datapath (rs1/rs2/aluControl -> rd/zero) among NUM_REQ requesters in the pipeline, e.g. the execute stage, the branch-compare unit and the address-generation unit.
- Arbitrates round-robin, drives the ALU operand and control lines from the granted requester, and captures rd/zero into a registered response slot.
- The response slot carries a requester ID and uses a valid/ready handshake.

---
 rtl/alu_share_arbiter_if.sv | 35 +++
 rtl/alu_share_arbiter.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter_if.sv
// Bundles the requester, ALU and response signals of alu_share_arbiter.
// slave is the arbiter's view and master is the view of the surrounding pipeline/ALU.
interface alu_share_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = 2
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_rs1;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_rs2;
  logic [NUM_REQ*4-1:0]          req_ctrl;

  logic [DATA_WIDTH-1:0]         alu_rs1;
  logic [DATA_WIDTH-1:0]         alu_rs2;
  logic [3:0]                    alu_control;
  logic [DATA_WIDTH-1:0]         alu_rd;
  logic                          alu_zero;

  logic                          rsp_valid;
  logic                          rsp_ready;
  logic [DATA_WIDTH-1:0]         rsp_data;
  logic                          rsp_zero;
  logic [ID_WIDTH-1:0]           rsp_id;

  modport slave (
    input  req_valid, req_rs1, req_rs2, req_ctrl, alu_rd, alu_zero, rsp_ready,
    output req_ready, alu_rs1, alu_rs2, alu_control, rsp_valid, rsp_data, rsp_zero, rsp_id
  );

  modport master (
    output req_valid, req_rs1, req_rs2, req_ctrl, alu_rd, alu_zero, rsp_ready,
    input  req_ready, alu_rs1, alu_rs2, alu_control, rsp_valid, rsp_data, rsp_zero, rsp_id
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU among NUM_REQ requesters; ALU_ARB_STATS_EN adds op/stall counters.
// Latency: request accepted in cycle N, result on rsp_* in cycle N+1; one op per cycle.
// Backpressure: slot full and rsp_ready low blocks all grants and holds rsp_*; draining and refilling may share a cycle.
module alu_share_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = 2
) (
  input  logic               clock,
  input  logic               reset,
  alu_share_arbiter_if.slave bus
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [31:0]        stat_ops,
  output logic [31:0]        stat_stall
`endif
);

  localparam int IW = ID_WIDTH + 1;

  typedef enum logic {IDLE, FULL} state_t;

  state_t                state_q, state_d;
  logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_zero_q, rsp_zero_d;
  logic [ID_WIDTH-1:0]   rsp_id_q, rsp_id_d;

  logic [ID_WIDTH-1:0]   gnt_idx;
  logic [ID_WIDTH-1:0]   sel_idx;
  logic [IW-1:0]         idx_w;
  logic                  found;
  logic                  any_vld;
  logic                  can_issue;
  logic                  gnt_act;
  logic                  xfer;
  logic [NUM_REQ-1:0]    ready_vec;

  assign any_vld   = |bus.req_valid;
  assign can_issue = (state_q == IDLE) || bus.rsp_ready;
  assign gnt_act   = can_issue && any_vld;
  assign xfer      = gnt_act && !reset;

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    gnt_idx = rr_ptr_q;
    found   = 1'b0;
    idx_w   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_w = {1'b0, rr_ptr_q} + IW'(k);
      if (idx_w >= IW'(NUM_REQ)) begin
        idx_w = idx_w - IW'(NUM_REQ);
      end
      if (!found && bus.req_valid[idx_w[ID_WIDTH-1:0]]) begin
        found   = 1'b1;
        gnt_idx = idx_w[ID_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    ready_vec = '0;
    if (xfer) begin
      ready_vec[gnt_idx] = 1'b1;
    end
  end

  // Idle ALU inputs follow rr_ptr so they never float or toggle needlessly.
  assign sel_idx         = gnt_act ? gnt_idx : rr_ptr_q;
  assign bus.alu_rs1     = bus.req_rs1[int'(sel_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign bus.alu_rs2     = bus.req_rs2[int'(sel_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign bus.alu_control = bus.req_ctrl[int'(sel_idx)*4 +: 4];
  assign bus.req_ready   = ready_vec;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_zero_d  = rsp_zero_q;
    rsp_id_d    = rsp_id_q;
    if (xfer) begin
      state_d     = FULL;
      rsp_valid_d = 1'b1;
      rsp_data_d  = bus.alu_rd;
      rsp_zero_d  = bus.alu_zero;
      rsp_id_d    = gnt_idx;
      rr_ptr_d    = (gnt_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end else if (state_q == FULL && bus.rsp_ready) begin
      state_d     = IDLE;
      rsp_valid_d = 1'b0;
    end
  end

`ifdef ALU_ARB_STATS_EN
  logic [31:0] stat_ops_q, stat_ops_d;
  logic [31:0] stat_stall_q, stat_stall_d;

  always_comb begin
    stat_ops_d   = stat_ops_q + 32'(xfer);
    stat_stall_d = stat_stall_q + 32'(rsp_valid_q && !bus.rsp_ready && any_vld);
  end

  assign stat_ops   = stat_ops_q;
  assign stat_stall = stat_stall_q;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_id_q     <= '0;
`ifdef ALU_ARB_STATS_EN
      stat_ops_q   <= '0;
      stat_stall_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_id_q     <= rsp_id_d;
`ifdef ALU_ARB_STATS_EN
      stat_ops_q   <= stat_ops_d;
      stat_stall_q <= stat_stall_d;
`endif
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_zero  = rsp_zero_q;
  assign bus.rsp_id    = rsp_id_q;

endmodule
